// File: rtl/strobe_gen.sv
// Programmable sample-rate strobe generator: NCH phase-staggered strobes, a 50% duty
// divided clock, a period-end pulse and a strobe[0] sample counter, all registered.
module strobe_gen #(
  parameter int DIV_DEFAULT = 20,
  parameter int DW          = 16,
  parameter int NCH         = 2,
  parameter int PH_STEP     = 10,
  parameter int CW          = 32
) (
  input  logic           clk,
  input  logic           nrst,
  input  logic           en,
  input  logic           div_ld,
  input  logic [DW-1:0]  div_val,
  output logic [NCH-1:0] strobe,
  output logic           clk_out,
  output logic           period_end,
  output logic [CW-1:0]  sample_cnt,
  output logic           cfg_err
);

  localparam int            MAX_PH  = (NCH - 1) * PH_STEP;
  localparam logic [DW-1:0] DIV_DEF = DW'(DIV_DEFAULT);
  localparam logic          DEF_BAD = (MAX_PH >= DIV_DEFAULT);

  logic [DW-1:0]  cnt_q, cnt_d;
  logic [DW-1:0]  div_act_q, div_shd_q;
  logic           pend_q;
  logic [NCH-1:0] strobe_q;
  logic           clk_out_q, pe_q, err_q;
  logic [CW-1:0]  scnt_q;

  logic           wrap, ld_ok, ld_bad, apply, phase_bad;
  logic [DW-1:0]  div_nxt, half;
  logic [NCH-1:0] hit;

  // Per-channel phase decode; a phase at or beyond the period is never reached
  // because cnt always stays below div_act.
  for (genvar k = 0; k < NCH; k++) begin : g_ph
    assign hit[k] = (32'(cnt_q) == 32'(k * PH_STEP));
  end

  always_comb begin
    wrap      = en && (cnt_q == div_act_q - DW'(1));
    cnt_d     = wrap ? '0 : cnt_q + DW'(1);
    ld_ok     = div_ld && (div_val >= DW'(2));
    ld_bad    = div_ld && (div_val < DW'(2));
    // A load on the wrap edge takes effect at that same wrap.
    div_nxt   = ld_ok ? div_val : div_shd_q;
    apply     = wrap && (ld_ok || pend_q);
    phase_bad = (32'(MAX_PH) >= 32'(div_nxt));
    half      = div_act_q >> 1;
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      cnt_q     <= '0;
      div_act_q <= DIV_DEF;
      div_shd_q <= DIV_DEF;
      pend_q    <= 1'b0;
      strobe_q  <= '0;
      clk_out_q <= 1'b0;
      pe_q      <= 1'b0;
      scnt_q    <= '0;
      err_q     <= DEF_BAD;
    end else begin
      if (en) begin
        cnt_q     <= cnt_d;
        strobe_q  <= hit;
        pe_q      <= wrap;
        clk_out_q <= (cnt_q < half);
        if (hit[0]) scnt_q <= scnt_q + CW'(1);
      end else begin
        strobe_q <= '0;
        pe_q     <= 1'b0;
      end

      if (apply) begin
        div_act_q <= div_nxt;
        pend_q    <= 1'b0;
      end else if (ld_ok) begin
        pend_q    <= 1'b1;
      end

      if (ld_ok) div_shd_q <= div_val;

      if (ld_bad || (apply && phase_bad)) err_q <= 1'b1;
    end
  end

  assign strobe     = strobe_q;
  assign clk_out    = clk_out_q;
  assign period_end = pe_q;
  assign sample_cnt = scnt_q;
  assign cfg_err    = err_q;

endmodule
